// File: rtl/icache_pkg.sv
// Shared widths, FSM state type and address-field helpers for the instruction cache.
package icache_pkg;

    localparam int ADDR_W     = 10;
    localparam int LINES      = 8;
    localparam int IDX_W      = 3;
    localparam int OFF_W      = 4;
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W;
    localparam int BLOCK_W    = 128;
    localparam int WORD_W     = 32;
    localparam int WSEL_W     = OFF_W - 2;
    localparam int BLK_ADDR_W = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic logic [WSEL_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
        return a[OFF_W-1:2];
    endfunction

    // Byte 0 of the block sits in bits [7:0], so word w starts at bit 32*w.
    function automatic logic [WORD_W-1:0] word_select(input logic [BLOCK_W-1:0] blk,
                                                      input logic [WSEL_W-1:0]  w);
        return blk[{w, 5'b00000} +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// One combinational read port, one synchronous write port; valid bits clear asynchronously.
module icache_line_store
    import icache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_data,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [BLOCK_W-1:0] wr_data
);

    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tags [LINES];
    logic [BLOCK_W-1:0] data [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are never trusted while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: zero-cycle hits, blocking refill on a miss.
//   state    | meaning
//   IDLE     | serve hits; a miss raises busywait and launches a refill
//   MEM_READ | mem_read held high until memory drops mem_busywait
//   UPDATE   | write the captured block, tag and valid into the line
module icache
    import icache_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  fetch,
    input  logic [ADDR_W-1:0]     address,
    output logic [WORD_W-1:0]     instruction,
    output logic                  busywait,
    output logic                  mem_read,
    output logic [BLK_ADDR_W-1:0] mem_address,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait
);

    state_t             state;
    logic [BLOCK_W-1:0] fill_data;

    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   index;
    logic [WSEL_W-1:0]  word;
    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;
    logic               hit;
    logic               unused_addr_bits;

    assign tag              = addr_tag(address);
    assign index            = addr_index(address);
    assign word             = addr_word(address);
    assign unused_addr_bits = ^address[1:0];

    icache_line_store u_store (
        .clk      (CLK),
        .rst      (RESET),
        .rd_index (index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (state == UPDATE),
        .wr_index (mem_address[IDX_W-1:0]),
        .wr_tag   (mem_address[BLK_ADDR_W-1:IDX_W]),
        .wr_data  (fill_data)
    );

    assign hit = fetch & line_valid & (line_tag == tag);

    // The refill target lives in mem_address from the miss onward, so later
    // changes on address/fetch cannot redirect an in-flight refill.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_address <= '0;
            fill_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch && !hit) begin
                        state       <= MEM_READ;
                        mem_read    <= 1'b1;
                        mem_address <= {tag, index};
                    end
                end
                MEM_READ: begin
                    if (!mem_busywait) begin
                        state     <= UPDATE;
                        mem_read  <= 1'b0;
                        fill_data <= mem_readdata;
                    end
                end
                UPDATE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    mem_read <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        busywait    = 1'b1;
        instruction = '0;
        if (RESET) begin
            busywait = 1'b0;
        end else if (state == IDLE) begin
            busywait = fetch & ~hit;
            if (hit) begin
                instruction = word_select(line_data, word);
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: behavioural block memory plus a queue of expected instructions.
module tb_icache;

    localparam int MEM_LAT   = 5;
    localparam int MISS_BUSY = 1 + MEM_LAT + 1;
    localparam logic [127:0] JUNK = {4{32'hDEADBEEF}};

    logic         CLK = 1'b0;
    logic         RESET;
    logic         fetch;
    logic [9:0]   address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata = JUNK;
    logic         mem_busywait = 1'b1;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           mem_cnt = 0;
    logic [5:0]   req_log[$];
    logic [31:0]  exp_q[$];

    icache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .fetch        (fetch),
        .address      (address),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    always #5 CLK = ~CLK;

    // Every instruction word holds its own byte address, so expected values follow from the PC alone.
    function automatic logic [127:0] block_for(input logic [5:0] ba);
        logic [127:0] b;
        for (int i = 0; i < 4; i++) b[i*32 +: 32] = 32'({ba, 4'b0000}) + 32'(i * 4);
        return b;
    endfunction

    always @(negedge CLK) begin
        if (mem_read !== 1'b1) begin
            mem_cnt      = 0;
            mem_busywait = 1'b1;
            mem_readdata = JUNK;
        end else begin
            if (mem_cnt == 0) req_log.push_back(mem_address);
            mem_cnt++;
            if (mem_cnt >= MEM_LAT) begin
                mem_busywait = 1'b0;
                mem_readdata = block_for(mem_address);
            end else begin
                mem_busywait = 1'b1;
                mem_readdata = JUNK;
            end
        end
    end

    task automatic do_fetch(input logic [9:0] a, output int busy, output int rd, output logic [31:0] instr);
        @(negedge CLK);
        fetch   = 1'b1;
        address = a;
        #1;
        busy = 0;
        rd   = 0;
        while (busywait === 1'b1 && busy < 50) begin
            busy++;
            if (mem_read === 1'b1) rd++;
            @(negedge CLK);
            #1;
        end
        instr = instruction;
    endtask

    task automatic test_reset();
        RESET   = 1'b1;
        fetch   = 1'b0;
        address = '0;
        repeat (2) @(negedge CLK);
        #1;
        n_cmp++; if (busywait !== 1'b0) begin n_bad++; $display("FAIL reset_busywait got %b want 0", busywait); end
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL reset_mem_read got %b want 0", mem_read); end
        n_cmp++; if (mem_address !== 6'h00) begin n_bad++; $display("FAIL reset_mem_address got %h want 00", mem_address); end
        n_cmp++; if (instruction !== 32'h0) begin n_bad++; $display("FAIL reset_instruction got %h want 0", instruction); end
        fetch   = 1'b1;
        address = 10'h3F0;
        #1;
        n_cmp++; if (busywait !== 1'b0) begin n_bad++; $display("FAIL reset_fetch_busywait got %b want 0", busywait); end
        fetch = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_cold_miss();
        int busy, rd;
        logic [31:0] instr, exp;
        req_log.delete();
        exp_q.push_back(32'h0000_0000);
        do_fetch(10'h000, busy, rd, instr);
        exp = exp_q.pop_front();
        n_cmp++; if (instr !== exp) begin n_bad++; $display("FAIL cold_instr got %h want %h", instr, exp); end
        n_cmp++; if (busy != MISS_BUSY) begin n_bad++; $display("FAIL cold_busy_cycles got %0d want %0d", busy, MISS_BUSY); end
        n_cmp++; if (rd != MEM_LAT) begin n_bad++; $display("FAIL cold_mem_read_cycles got %0d want %0d", rd, MEM_LAT); end
        n_cmp++; if (req_log.size() != 1) begin n_bad++; $display("FAIL cold_req_count got %0d want 1", req_log.size()); end
        n_cmp++; if (req_log.size() > 0 && req_log[0] !== 6'h00) begin n_bad++; $display("FAIL cold_mem_address got %h want 00", req_log[0]); end
    endtask

    task automatic test_seq_hits();
        int busy, rd;
        logic [31:0] instr, exp;
        logic [9:0] seq[3] = '{10'h004, 10'h008, 10'h00C};
        req_log.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'(seq[i]));
            do_fetch(seq[i], busy, rd, instr);
            exp = exp_q.pop_front();
            n_cmp++; if (instr !== exp) begin n_bad++; $display("FAIL hit_instr[%0d] got %h want %h", i, instr, exp); end
            n_cmp++; if (busy != 0) begin n_bad++; $display("FAIL hit_busy[%0d] got %0d want 0", i, busy); end
            n_cmp++; if (rd != 0) begin n_bad++; $display("FAIL hit_mem_read[%0d] got %0d want 0", i, rd); end
        end
        n_cmp++; if (req_log.size() != 0) begin n_bad++; $display("FAIL hit_req_count got %0d want 0", req_log.size()); end
    endtask

    task automatic test_conflict();
        int busy, rd;
        logic [31:0] instr, exp;
        logic [9:0] seq[4] = '{10'h090, 10'h010, 10'h090, 10'h094};
        int exp_busy[4] = '{MISS_BUSY, MISS_BUSY, MISS_BUSY, 0};
        req_log.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'(seq[i]));
            do_fetch(seq[i], busy, rd, instr);
            exp = exp_q.pop_front();
            n_cmp++; if (instr !== exp) begin n_bad++; $display("FAIL conflict_instr[%0d] got %h want %h", i, instr, exp); end
            n_cmp++; if (busy != exp_busy[i]) begin n_bad++; $display("FAIL conflict_busy[%0d] got %0d want %0d", i, busy, exp_busy[i]); end
        end
        n_cmp++; if (req_log.size() != 3) begin n_bad++; $display("FAIL conflict_req_count got %0d want 3", req_log.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < req_log.size()) begin
                n_cmp++; if (req_log[i] !== seq[i][9:4]) begin n_bad++; $display("FAIL conflict_mem_address[%0d] got %h want %h", i, req_log[i], seq[i][9:4]); end
            end
        end
    endtask

    task automatic test_addr_change();
        int n, busy, rd;
        logic [31:0] instr, exp;
        req_log.delete();
        @(negedge CLK);
        fetch   = 1'b1;
        address = 10'h020;
        repeat (2) @(negedge CLK);
        #1;
        address = 10'h3F0;
        #1;
        n_cmp++; if (mem_address !== 6'h02) begin n_bad++; $display("FAIL chg_mem_address got %h want 02", mem_address); end
        n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL chg_mem_read got %b want 1", mem_read); end
        @(negedge CLK);
        #1;
        n_cmp++; if (mem_address !== 6'h02) begin n_bad++; $display("FAIL chg_mem_address_hold got %h want 02", mem_address); end
        exp_q.push_back(32'h0000_03F0);
        n = 0;
        while (busywait === 1'b1 && n < 100) begin
            n++;
            @(negedge CLK);
            #1;
        end
        exp = exp_q.pop_front();
        n_cmp++; if (instruction !== exp) begin n_bad++; $display("FAIL chg_new_instr got %h want %h", instruction, exp); end
        n_cmp++; if (req_log.size() != 2) begin n_bad++; $display("FAIL chg_req_count got %0d want 2", req_log.size()); end
        if (req_log.size() == 2) begin
            n_cmp++; if (req_log[0] !== 6'h02) begin n_bad++; $display("FAIL chg_first_req got %h want 02", req_log[0]); end
            n_cmp++; if (req_log[1] !== 6'h3F) begin n_bad++; $display("FAIL chg_second_req got %h want 3F", req_log[1]); end
        end
        exp_q.push_back(32'h0000_0020);
        do_fetch(10'h020, busy, rd, instr);
        exp = exp_q.pop_front();
        n_cmp++; if (instr !== exp) begin n_bad++; $display("FAIL chg_orig_instr got %h want %h", instr, exp); end
        n_cmp++; if (busy != 0) begin n_bad++; $display("FAIL chg_orig_busy got %0d want 0", busy); end
    endtask

    task automatic test_reset_mid_refill();
        int busy, rd;
        logic [31:0] instr, exp;
        @(negedge CLK);
        fetch   = 1'b1;
        address = 10'h200;
        repeat (3) @(negedge CLK);
        #1;
        n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL rst_pre_mem_read got %b want 1", mem_read); end
        RESET = 1'b1;
        #1;
        n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL rst_mid_mem_read got %b want 0", mem_read); end
        n_cmp++; if (busywait !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busywait got %b want 0", busywait); end
        n_cmp++; if (mem_address !== 6'h00) begin n_bad++; $display("FAIL rst_mid_mem_address got %h want 00", mem_address); end
        fetch = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        req_log.delete();
        exp_q.push_back(32'h0000_0000);
        do_fetch(10'h000, busy, rd, instr);
        exp = exp_q.pop_front();
        n_cmp++; if (busy != MISS_BUSY) begin n_bad++; $display("FAIL rst_cleared_busy got %0d want %0d", busy, MISS_BUSY); end
        n_cmp++; if (instr !== exp) begin n_bad++; $display("FAIL rst_cleared_instr got %h want %h", instr, exp); end
        exp_q.push_back(32'h0000_0200);
        do_fetch(10'h200, busy, rd, instr);
        exp = exp_q.pop_front();
        n_cmp++; if (busy != MISS_BUSY) begin n_bad++; $display("FAIL rst_refetch_busy got %0d want %0d", busy, MISS_BUSY); end
        n_cmp++; if (instr !== exp) begin n_bad++; $display("FAIL rst_refetch_instr got %h want %h", instr, exp); end
        n_cmp++; if (req_log.size() != 2) begin n_bad++; $display("FAIL rst_req_count got %0d want 2", req_log.size()); end
    endtask

    task automatic test_no_fetch();
        logic [9:0] seq[4] = '{10'h200, 10'h3F0, 10'h154, 10'h000};
        req_log.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            fetch   = 1'b0;
            address = seq[i];
            #1;
            n_cmp++; if (busywait !== 1'b0) begin n_bad++; $display("FAIL nofetch_busywait[%0d] got %b want 0", i, busywait); end
            n_cmp++; if (instruction !== 32'h0) begin n_bad++; $display("FAIL nofetch_instr[%0d] got %h want 0", i, instruction); end
            n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL nofetch_mem_read[%0d] got %b want 0", i, mem_read); end
        end
        repeat (3) @(negedge CLK);
        n_cmp++; if (req_log.size() != 0) begin n_bad++; $display("FAIL nofetch_req_count got %0d want 0", req_log.size()); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_seq_hits();
        test_conflict();
        test_addr_change();
        test_reset_mid_refill();
        test_no_fetch();
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
